// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase controller.
// Phase encoding is visible on the phase output and must stay stable.
package traffic_pkg;

   typedef enum logic [1:0] {
      ALLRED = 2'd0,
      GREEN  = 2'd1,
      YELLOW = 2'd2
   } phase_e;

   // Per-direction light encoding {red,yellow,green}
   localparam logic [2:0] L_RED = 3'b100;
   localparam logic [2:0] L_YEL = 3'b010;
   localparam logic [2:0] L_GRN = 3'b001;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase countdown: loads (duration-1) on phase entry, steps down on tick_en,
// and flags expiry on a tick seen at zero. freeze holds the count and masks expiry.
module phase_timer #(
   parameter int unsigned W       = 3,
   parameter int unsigned RST_VAL = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         tick_en,
   input  logic         freeze,
   output logic         expired
);

   logic [W-1:0] cnt_q, cnt_d;

   assign expired = tick_en && !freeze && (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (tick_en && !freeze && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= W'(RST_VAL);
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic phase controller: round-robin green/yellow/all-red sequencing over
// NUM_DIR approaches with demand skipping, green extension and emergency pre-emption.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned NUM_DIR    = 4,
   parameter int unsigned GREEN_CYC  = 5,
   parameter int unsigned YELLOW_CYC = 2,
   parameter int unsigned ALLRED_CYC = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       tick_en,
   input  logic [NUM_DIR-1:0]         demand,
   input  logic                       emerg_req,
   input  logic [$clog2(NUM_DIR)-1:0] emerg_dir,
   output logic [NUM_DIR*3-1:0]       lights,
   output logic [$clog2(NUM_DIR)-1:0] active_dir,
   output logic [1:0]                 phase
);

   localparam int unsigned DW   = $clog2(NUM_DIR);
   localparam int unsigned MAXD = max3(GREEN_CYC, YELLOW_CYC, ALLRED_CYC);
   localparam int unsigned TW   = $clog2(MAXD) + 1;

   localparam logic [TW-1:0] LD_GRN = TW'(GREEN_CYC - 1);
   localparam logic [TW-1:0] LD_YEL = TW'(YELLOW_CYC - 1);
   localparam logic [TW-1:0] LD_ARD = TW'(ALLRED_CYC - 1);

   localparam logic [NUM_DIR-1:0] ONE_HOT0 = NUM_DIR'(1);

   phase_e               state_q, state_d;
   logic [DW-1:0]        dir_q, dir_d;
   logic [NUM_DIR*3-1:0] lights_q, lights_d;

   logic          tmr_load;
   logic [TW-1:0] tmr_value;
   logic          tmr_freeze;
   logic          tmr_exp;

   logic          emerg_ok;
   logic [DW-1:0] rr_dir;
   logic          own_only;

   // Out-of-range emergency directions are ignored when NUM_DIR is not a power of two
   if ((1 << DW) == NUM_DIR) begin : g_emerg_pow2
      assign emerg_ok = emerg_req;
   end else begin : g_emerg_range
      assign emerg_ok = emerg_req && (32'(emerg_dir) < NUM_DIR);
   end

   // Kept outside the FSM block so expiry does not loop back through it
   assign tmr_freeze = (state_q == GREEN) && emerg_ok && (emerg_dir == dir_q);

   assign own_only = (demand == (ONE_HOT0 << dir_q));

   phase_timer #(
      .W       (TW),
      .RST_VAL (ALLRED_CYC - 1)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .load    (tmr_load),
      .value   (tmr_value),
      .tick_en (tick_en),
      .freeze  (tmr_freeze),
      .expired (tmr_exp)
   );

   always_comb begin : rr_search
      int unsigned idx;
      logic        found;
      idx    = 0;
      found  = 1'b0;
      rr_dir = DW'((32'(dir_q) + 32'd1) % NUM_DIR);
      for (int unsigned k = 1; k <= NUM_DIR; k++) begin
         idx = (32'(dir_q) + k) % NUM_DIR;
         if (!found && demand[DW'(idx)]) begin
            found  = 1'b1;
            rr_dir = DW'(idx);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      tmr_load  = 1'b0;
      tmr_value = LD_ARD;
      case (state_q)
         ALLRED: begin
            if (tmr_exp) begin
               state_d   = GREEN;
               dir_d     = emerg_ok ? emerg_dir : rr_dir;
               tmr_load  = 1'b1;
               tmr_value = LD_GRN;
            end
         end
         GREEN: begin
            if (emerg_ok && (emerg_dir != dir_q)) begin
               state_d   = YELLOW;
               tmr_load  = 1'b1;
               tmr_value = LD_YEL;
            end else if (tmr_exp) begin
               tmr_load = 1'b1;
               if (own_only) begin
                  tmr_value = LD_GRN;
               end else begin
                  state_d   = YELLOW;
                  tmr_value = LD_YEL;
               end
            end
         end
         YELLOW: begin
            if (tmr_exp) begin
               state_d   = ALLRED;
               tmr_load  = 1'b1;
               tmr_value = LD_ARD;
            end
         end
         default: begin
            state_d   = ALLRED;
            tmr_load  = 1'b1;
            tmr_value = LD_ARD;
         end
      endcase
   end

   // Lights are decoded from next state so they register on the same edge as the phase
   always_comb begin
      lights_d = {NUM_DIR{L_RED}};
      for (int unsigned i = 0; i < NUM_DIR; i++) begin
         if (32'(dir_d) == i) begin
            if (state_d == GREEN) begin
               lights_d[3*i +: 3] = L_GRN;
            end else if (state_d == YELLOW) begin
               lights_d[3*i +: 3] = L_YEL;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ALLRED;
         dir_q    <= DW'(NUM_DIR - 1);
         lights_q <= {NUM_DIR{L_RED}};
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         lights_q <= lights_d;
      end
   end

   assign lights     = lights_q;
   assign active_dir = dir_q;
   assign phase      = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: tick-counting reference model checked every cycle,
// plus directed scenarios with hand-computed light/phase/direction values.
module tb_traffic_phase_ctrl;

   localparam int N  = 4;
   localparam int G  = 5;
   localparam int Y  = 2;
   localparam int AR = 1;

   logic        clk       = 1'b0;
   logic        reset     = 1'b0;
   logic        tick_en   = 1'b1;
   logic [3:0]  demand    = 4'b0000;
   logic        emerg_req = 1'b0;
   logic [1:0]  emerg_dir = 2'd0;
   logic [11:0] lights;
   logic [1:0]  active_dir;
   logic [1:0]  phase;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int tctr  = 0;
   bit tick_div = 1'b0;

   always #5 clk = ~clk;

   traffic_phase_ctrl #(
      .NUM_DIR    (N),
      .GREEN_CYC  (G),
      .YELLOW_CYC (Y),
      .ALLRED_CYC (AR)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tick_en    (tick_en),
      .demand     (demand),
      .emerg_req  (emerg_req),
      .emerg_dir  (emerg_dir),
      .lights     (lights),
      .active_dir (active_dir),
      .phase      (phase)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0=all-red 1=green 2=yellow, m_left = ticks still owed
   int m_ph   = 0;
   int m_dir  = N - 1;
   int m_left = AR;

   function automatic int rr_pick(input logic [3:0] dm, input int from);
      for (int k = 1; k <= N; k++) begin
         if (dm[(from + k) % N]) return (from + k) % N;
      end
      return (from + 1) % N;
   endfunction

   function automatic logic [11:0] exp_lights(input int ph, input int dr);
      logic [11:0] v;
      v = 12'h924;
      for (int i = 0; i < N; i++) begin
         if (i == dr && ph == 1) v[3*i +: 3] = 3'b001;
         if (i == dr && ph == 2) v[3*i +: 3] = 3'b010;
      end
      return v;
   endfunction

   always @(posedge clk or posedge reset) begin : model
      int ph, dr, lf;
      if (reset) begin
         m_ph   <= 0;
         m_dir  <= N - 1;
         m_left <= AR;
      end else begin
         ph = m_ph;
         dr = m_dir;
         lf = m_left;
         if (ph == 1 && emerg_req && int'(emerg_dir) != dr) begin
            ph = 2;
            lf = Y;
         end else if (ph == 1 && emerg_req) begin
            lf = m_left;
         end else if (tick_en) begin
            lf = lf - 1;
            if (lf == 0) begin
               case (ph)
                  0: begin
                     ph = 1;
                     lf = G;
                     dr = emerg_req ? int'(emerg_dir) : rr_pick(demand, dr);
                  end
                  1: begin
                     lf = G;
                     if (demand != (4'b0001 << dr)) begin
                        ph = 2;
                        lf = Y;
                     end
                  end
                  default: begin
                     ph = 0;
                     lf = AR;
                  end
               endcase
            end
         end
         m_ph   <= ph;
         m_dir  <= dr;
         m_left <= lf;
      end
   end

   always @(negedge clk) begin : compare
      int   nonred;
      logic oh_ok;
      chk("model_lights", 32'(lights), 32'(exp_lights(m_ph, m_dir)));
      chk("model_phase", 32'(phase), 32'(m_ph));
      chk("model_dir", 32'(active_dir), 32'(m_dir));
      nonred = 0;
      oh_ok  = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (!$onehot(lights[3*i +: 3])) oh_ok = 1'b0;
         if (lights[3*i +: 3] != 3'b100) nonred++;
      end
      chk("inv_onehot", 32'(oh_ok), 32'd1);
      chk("inv_single_nonred", 32'(nonred <= 1), 32'd1);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         cyc++;
         tctr++;
         tick_en = tick_div ? ((tctr % 4) == 0) : 1'b1;
      end
   endtask

   task automatic go(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic expect_st(input string name, input int ph, input int dr, input logic [11:0] lt);
      chk({name, "_phase"}, 32'(phase), 32'(ph));
      chk({name, "_dir"}, 32'(active_dir), 32'(dr));
      chk({name, "_lights"}, 32'(lights), 32'(lt));
   endtask

   task automatic release_rst();
      reset   = 1'b0;
      cyc     = 0;
      tctr    = 0;
      tick_en = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      expect_st("rst", 0, 3, 12'h924);
      step(2);
      release_rst();
   endtask

   initial begin
      reset = 1'b1;
      step(2);

      // Full rotation with every approach demanding
      demand = 4'b1111;
      do_reset();
      go(1);  expect_st("rot_c1",  1, 0, 12'h921);
      go(5);  expect_st("rot_c5",  1, 0, 12'h921);
      go(6);  expect_st("rot_c6",  2, 0, 12'h922);
      go(7);  expect_st("rot_c7",  2, 0, 12'h922);
      go(8);  expect_st("rot_c8",  0, 0, 12'h924);
      go(9);  expect_st("rot_c9",  1, 1, 12'h90C);
      go(25); expect_st("rot_c25", 1, 3, 12'h324);
      go(33); expect_st("rot_c33", 1, 0, 12'h921);

      // Sole demand holds green; a competing request ends it at the next expiry
      demand = 4'b1000;
      do_reset();
      go(1);  expect_st("hold_c1",  1, 3, 12'h324);
      go(11); expect_st("hold_c11", 1, 3, 12'h324);
      demand = 4'b1010;
      go(16); expect_st("hold_c16", 2, 3, 12'h524);
      go(18); expect_st("hold_c18", 0, 3, 12'h924);
      go(19); expect_st("hold_c19", 1, 1, 12'h90C);

      // No demand at all: rotation still steps one direction at a time
      demand = 4'b0000;
      do_reset();
      go(1);  expect_st("idle_c1", 1, 0, 12'h921);
      go(9);  expect_st("idle_c9", 1, 1, 12'h90C);

      // Emergency pre-emption to dir2 from dir0 green cycle 2
      demand = 4'b1111;
      do_reset();
      go(2);
      emerg_req = 1'b1;
      emerg_dir = 2'd2;
      go(3);  expect_st("emg_c3",  2, 0, 12'h922);
      go(5);  expect_st("emg_c5",  0, 0, 12'h924);
      go(6);  expect_st("emg_c6",  1, 2, 12'h864);
      go(16); expect_st("emg_c16", 1, 2, 12'h864);
      emerg_req = 1'b0;
      go(20); expect_st("emg_c20", 1, 2, 12'h864);
      go(21); expect_st("emg_c21", 2, 2, 12'h8A4);

      // Reset asserted mid-yellow forces all-red before the next edge
      demand = 4'b1111;
      do_reset();
      go(6);  expect_st("mrst_c6", 2, 0, 12'h922);
      #2;
      reset = 1'b1;
      #1;
      expect_st("mrst_now", 0, 3, 12'h924);
      step(2);
      release_rst();
      go(1);  expect_st("mrst_c1", 1, 0, 12'h921);
      go(9);  expect_st("mrst_c9", 1, 1, 12'h90C);

      // Timebase enable every 4th cycle stretches every phase fourfold
      tick_div = 1'b1;
      demand   = 4'b1111;
      do_reset();
      go(1);  expect_st("slow_c1",  1, 0, 12'h921);
      go(20); expect_st("slow_c20", 1, 0, 12'h921);
      go(21); expect_st("slow_c21", 2, 0, 12'h922);
      go(28); expect_st("slow_c28", 2, 0, 12'h922);
      go(29); expect_st("slow_c29", 0, 0, 12'h924);
      go(32); expect_st("slow_c32", 0, 0, 12'h924);
      go(33); expect_st("slow_c33", 1, 1, 12'h90C);
      tick_div = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/traffic_phase_ctrl.md
TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIR, default 4, meaning number of approach directions (legal 2..8).
REQ-002 The block SHALL have parameter GREEN_CYC, default 5, meaning green duration in ticks (>=1).
REQ-003 The block SHALL have parameter YELLOW_CYC, default 2, meaning yellow duration in ticks (>=1).
REQ-004 The block SHALL have parameter ALLRED_CYC, default 1, meaning all-red clearance duration in ticks (>=1).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port tick_en, input, 1 bit: timebase enable; the timer advances only on cycles where it is 1.
REQ-008 The block SHALL have port demand, input, NUM_DIR bits: per-direction vehicle presence.
REQ-009 The block SHALL have port emerg_req, input, 1 bit: emergency pre-emption request, level-sensitive.
REQ-010 The block SHALL have port emerg_dir, input, $clog2(NUM_DIR) bits: direction to pre-empt to.
REQ-011 The block SHALL have port lights, output, NUM_DIR x 3 bits: per direction {red,yellow,green}, one-hot.
REQ-012 The block SHALL have port active_dir, output, $clog2(NUM_DIR) bits: direction currently owning the phase.
REQ-013 The block SHALL have port phase, output, 2 bits: current FSM state encoding.

Function
REQ-014 The FSM SHALL have states ALLRED, GREEN and YELLOW; outputs SHALL be Moore, registered, and change on the edge where the state changes.
REQ-015 The phase timer SHALL be loaded with (duration-1) on state entry, decrement on tick_en, and expire on a cycle with tick_en=1 and count=0; transition takes effect at that edge.
REQ-016 Transitions SHALL be GREEN->YELLOW, YELLOW->ALLRED, and ALLRED->GREEN, each on expiry.
REQ-017 In GREEN, lights[active_dir] SHALL be 3'b001; in YELLOW it SHALL be 3'b010; all other directions, and all directions in ALLRED, SHALL be 3'b100.
REQ-018 On ALLRED expiry, next active_dir SHALL be the first i with demand[i]=1, searching round-robin from active_dir+1 with wrap NUM_DIR-1->0.
REQ-019 If demand is all-zero at ALLRED expiry, next active_dir SHALL be active_dir+1 (wrapping).
REQ-020 On GREEN expiry, if demand[active_dir]=1 and no other demand bit is set, GREEN SHALL be re-entered (timer reloaded), repeating without limit.
REQ-021 If emerg_req=1 in GREEN and active_dir!=emerg_dir, the block SHALL enter YELLOW on the next edge regardless of timer.
REQ-022 If emerg_req=1 in GREEN and active_dir==emerg_dir, the timer SHALL freeze; countdown SHALL resume from its held value when emerg_req drops.
REQ-023 If emerg_req=1 at ALLRED expiry, next active_dir SHALL be emerg_dir, overriding REQ-018 and REQ-019.
REQ-024 YELLOW and ALLRED SHALL never be shortened; emerg_req during them SHALL act only via REQ-023.
REQ-025 At most one direction SHALL be non-red in any cycle.

Reset
REQ-026 While reset=1, the block SHALL be asynchronously forced to phase=ALLRED, all lights=3'b100, active_dir=NUM_DIR-1, and timer=ALLRED_CYC-1.
REQ-027 Assertion of reset mid-phase SHALL abort immediately; after release, the first green SHALL follow the REQ-018 search from direction 0.

Structure
REQ-028 A shared package traffic_pkg SHALL hold the state enum (ALLRED=0, GREEN=1, YELLOW=2) and the light constants L_RED, L_YEL and L_GRN.
REQ-029 The countdown SHALL be implemented as a sub-module phase_timer (load, value, tick_en, freeze, expired), with width $clog2(max duration)+1.

Verification (NUM_DIR=4, GREEN=5, YELLOW=2, ALLRED=1, tick_en=1 unless stated)
REQ-030 The bench SHALL cover: demand=4'b1111, reset released -> 1 cycle all red, dir0 green 5 cycles, yellow 2, all-red 1, dir1 green; full rotation = 32 cycles.
REQ-031 The bench SHALL cover: demand=4'b1000 -> dir3 green from cycle 1, held continuously with no yellow; then set demand[1] -> dir3 yellow at next expiry, and dir1 green 3 cycles later.
REQ-032 The bench SHALL cover: emerg_req=1, emerg_dir=2, asserted in dir0 green cycle 2 -> yellow on next edge for 2 cycles, all-red 1, dir2 green held while asserted; after release, the remaining green ticks elapse.
REQ-033 The bench SHALL cover: reset pulsed in the middle of yellow -> all lights 3'b100 immediately (before the next edge); restart per REQ-030.
REQ-034 The bench SHALL cover: tick_en=1 every 4th cycle -> green lasts 20 clocks, yellow 8, all-red 4.
REQ-035 The bench SHALL assert continuously that lights are one-hot per direction and REQ-025 holds.
